// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and default width shared by serial_sub.
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_sub.sv
// full_sub: single-bit full subtractor, d = a - b - bin with borrow-out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor d = a - b - bin, LSB first, one full_sub cell.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_brw, w_d, w_bout, w_last, w_load, w_run;
  full_sub u_fs (.a(r_a[0]), .b(r_b[0]), .bin(r_brw), .d(w_d), .bout(w_bout));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_load = r_state == IDLE && start;
  assign w_run  = r_state == RUN;
  always_comb begin
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_d   <= '0;
      r_brw <= 1'b0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_d   <= '0;
      r_brw <= bin;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_d   <= {w_d, r_d[WIDTH-1:1]};
      r_brw <= w_bout;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
  // partial results stay hidden while the operation is in flight
  assign d    = w_run ? '0 : r_d;
  assign bout = w_run ? 1'b0 : r_brw;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf, r_amsb, r_bmsb;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
    end else if (w_load) begin
      r_ovf  <= 1'b0;
      r_amsb <= a[WIDTH-1];
      r_bmsb <= b[WIDTH-1];
    end else if (w_run && w_last) begin
      r_ovf  <= (r_amsb != r_bmsb) && (w_d != r_amsb);
    end
  end
  assign ovf = r_ovf;
`endif
endmodule
